// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch FIFO with redirect flush and in-flight request draining
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [7:0]  out_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;
  state_e state_q, state_d;
  logic [7:0] fa_q, fa_d, pend_q, pend_d;
  logic req_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [7:0] addr_q [DEPTH];
  logic [15:0] instr_q [DEPTH];
  logic push, pop;
  assign mem_req = req_q;
  assign mem_addr = fa_q;
  assign out_valid = cnt_q != '0;
  assign out_addr = addr_q[rd_q];
  assign out_instr = instr_q[rd_q];
  assign pop = out_valid && out_ready;
  assign push = state_q == REQ && mem_ack && !redirect;
  always_comb begin
    cnt_d = redirect ? '0 : cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    state_d = state_q;
    fa_d = fa_q;
    pend_d = pend_q;
    case (state_q)
      IDLE: begin
        fa_d = redirect ? redirect_addr : fa_q;
        state_d = (redirect || cnt_q < FULL) ? REQ : IDLE;
      end
      REQ: begin
        fa_d = mem_ack ? (redirect ? redirect_addr : fa_q + 8'd1) : fa_q;
        pend_d = (!mem_ack && redirect) ? redirect_addr : pend_q;
        state_d = (!mem_ack && redirect) ? DRAIN : (push && cnt_d == FULL) ? IDLE : REQ;
      end
      DRAIN: begin
        fa_d = mem_ack ? (redirect ? redirect_addr : pend_q) : fa_q;
        pend_d = (!mem_ack && redirect) ? redirect_addr : pend_q;
        state_d = mem_ack ? REQ : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fa_q <= '0;
      pend_q <= '0;
      req_q <= 1'b0;
      cnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      fa_q <= fa_d;
      pend_q <= pend_d;
      req_q <= state_d != IDLE;
      cnt_q <= cnt_d;
      rd_q <= redirect ? '0 : rd_q + AW'(pop);
      wr_q <= redirect ? '0 : wr_q + AW'(push);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= fa_q;
      instr_q[wr_q] <= mem_rdata;
    end
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port redirect, input, 1, meaning a taken jump: flush and refetch.
REQ-005 SHALL have port redirect_addr, input, 8, meaning the jump target address.
REQ-006 SHALL have port mem_req, output, 1, meaning an instruction memory read request.
REQ-007 SHALL have port mem_addr, output, 8, meaning the read address.
REQ-008 SHALL have port mem_ack, input, 1, meaning the memory has accepted the read; mem_rdata is valid this cycle.
REQ-009 SHALL have port mem_rdata, input, 16, meaning the instruction word.
REQ-010 SHALL have port out_valid, output, 1, meaning the head entry is valid for the decoder.
REQ-011 SHALL have port out_ready, input, 1, meaning the decoder accepts the head.
REQ-012 SHALL have port out_instr, output, 16, meaning the head instruction word.
REQ-013 SHALL have port out_addr, output, 8, meaning the address of the head instruction.

Function
REQ-014 SHALL hold a fetch address register fa[7:0] and a FIFO of DEPTH entries {addr[7:0], instr[15:0]} with an occupancy count of 0..DEPTH.
REQ-015 SHALL implement three states: IDLE (mem_req=0), REQ (mem_req=1, mem_addr=fa), DRAIN (mem_req=1, result discarded).
REQ-016 SHALL drive mem_req and mem_addr from registers and SHALL hold both stable from assertion until the cycle where mem_req && mem_ack.
REQ-017 In IDLE, with no redirect and count < DEPTH, SHALL move to REQ in the next cycle.
REQ-018 In REQ, on ack without redirect, SHALL push {fa, mem_rdata} and set fa <= fa+1 (mod 256, so 255 wraps to 0); it SHALL stay in REQ if the post-cycle count < DEPTH, else go to IDLE.
REQ-019 Back-to-back acks in REQ SHALL sustain one push per cycle.
REQ-020 A decoder pop (out_valid && out_ready) SHALL remove the head; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-021 SHALL drive out_valid = (count != 0); out_instr and out_addr SHALL show the head entry and SHALL be stable while out_valid && !out_ready.
REQ-022 Redirect in any state SHALL empty the FIFO (count = 0 next cycle, out_valid = 0); a pop in the redirect cycle SHALL count as consumed.
REQ-023 Redirect in IDLE, or in REQ/DRAIN together with mem_ack, SHALL discard any ack data, set fa <= redirect_addr, and go to REQ next cycle.
REQ-024 Redirect in REQ without mem_ack SHALL go to DRAIN, record redirect_addr as pending target, and keep mem_req/mem_addr unchanged.
REQ-025 In DRAIN, mem_ack SHALL discard mem_rdata, load fa <= pending target, and go to REQ; no push SHALL occur.
REQ-026 A further redirect in DRAIN without ack SHALL overwrite the pending target and remain in DRAIN.
REQ-027 SHALL never push while full and never pop while empty; count SHALL never exceed DEPTH.

Reset
REQ-028 While rst_n=0 at a clock edge: state=IDLE, fa=0, count=0, mem_req=0, mem_addr=0, out_valid=0, pending target=0.
REQ-029 Reset SHALL take priority over redirect, mem_ack and pops; an in-flight request SHALL be abandoned (memory is reset with the block).
REQ-030 The first cycle after rst_n rises SHALL be IDLE, and mem_req=1 with mem_addr=0 SHALL follow one cycle later.

Verification
REQ-031 Streaming: mem_ack=1 always, out_ready=1 -> from the first ack onward, one instruction per cycle at out_addr 0,1,2,..., with out_instr matching the memory model.
REQ-032 Backpressure: out_ready=0, mem_ack=1 -> exactly 4 pushes (addr 0..3), then mem_req=0, out_valid held with out_addr=0; raising out_ready resumes fetch at addr 4.
REQ-033 Redirect during stalled request: mem_req=1 at addr 5, mem_ack=0, redirect to 0x40 -> DRAIN, mem_addr stays 5; ack 3 cycles later is dropped; next mem_addr=0x40, out_valid=0 until its ack.
REQ-034 Redirect coincident with ack, FIFO holding 3 entries -> out_valid=0 next cycle, ack data not pushed, mem_addr=redirect_addr next cycle.
REQ-035 Wrap: redirect to 0xFE, streaming -> out_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-036 Mid-operation reset: FIFO 2 entries, request pending, rst_n=0 for one cycle -> all outputs per REQ-028; first new request at mem_addr=0.
